// File: rtl/kcpsmx3_inc.sv
// Shared types and default sizes for the KCPSMX scratchpad slice.
package kcpsmx3_inc;

    localparam int SCRATCH_DATA_W = 8;
    localparam int SCRATCH_ADDR_W = 6;

    typedef enum logic [0:0] {
        SCR_IDLE  = 1'b0,
        SCR_CLEAR = 1'b1
    } scratch_clr_state_t;

endpackage

// File: rtl/kcpsmx_scratch_dp_if.sv
// Scratchpad bus: core read/write port A, debug read port B, clear control.
interface kcpsmx_scratch_dp_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] a_addr;
    logic              a_we;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] a_rdata;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_rdata;
    logic              clear_req;
    logic              busy;
    logic              clear_done;
    logic              wr_dropped;

    modport master (
        output a_addr, a_we, a_wdata, b_addr, clear_req,
        input  a_rdata, b_rdata, busy, clear_done, wr_dropped
    );

    modport slave (
        input  a_addr, a_we, a_wdata, b_addr, clear_req,
        output a_rdata, b_rdata, busy, clear_done, wr_dropped
    );
endinterface

// File: rtl/kcpsmx_scratch_clr.sv
// Clear-sweep FSM and write-port arbitration between the sweep and port A.
module kcpsmx_scratch_clr
    import kcpsmx3_inc::*;
#(
    parameter int              DATA_W         = SCRATCH_DATA_W,
    parameter int              ADDR_W         = SCRATCH_ADDR_W,
    parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0,
    parameter bit              CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_we,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              clear_req,
    output logic              busy,
    output logic              clear_done,
    output logic              wr_dropped,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    scratch_clr_state_t state_r, state_nxt_s;
    logic [ADDR_W-1:0]  cnt_r, cnt_nxt_s;
    logic               busy_r, clear_done_r, wr_dropped_r;

    // Next-state logic; clear_req is only honoured from IDLE.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            SCR_IDLE: begin
                if (clear_req) begin
                    state_nxt_s = SCR_CLEAR;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = SCR_IDLE;
                    cnt_nxt_s   = cnt_r;
                end
            end
            SCR_CLEAR: begin
                if (cnt_r == LAST_ADDR) begin
                    state_nxt_s = SCR_IDLE;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = SCR_CLEAR;
                    cnt_nxt_s   = cnt_r + ADDR_ONE;
                end
            end
            default: begin
                state_nxt_s = SCR_CLEAR;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // FSM state, sweep counter and registered status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= CLEAR_ON_RESET ? SCR_CLEAR : SCR_IDLE;
            cnt_r        <= '0;
            busy_r       <= CLEAR_ON_RESET;
            clear_done_r <= 1'b0;
            wr_dropped_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            busy_r       <= (state_nxt_s == SCR_CLEAR);
            clear_done_r <= (state_r == SCR_CLEAR) && (cnt_r == LAST_ADDR);
            wr_dropped_r <= a_we && (busy_r || clear_req);
        end
    end

    // Sweep owns the write port while busy; a port A write loses to a clear request.
    always_comb begin
        if (busy_r) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_r;
            mem_wdata = CLEAR_VALUE;
        end else begin
            mem_we    = a_we && !clear_req;
            mem_waddr = a_addr;
            mem_wdata = a_wdata;
        end
    end

    assign busy       = busy_r;
    assign clear_done = clear_done_r;
    assign wr_dropped = wr_dropped_r;

endmodule

// File: rtl/kcpsmx_scratch_dp.sv
// Dual-read-port scratchpad: array plus combinational or registered read paths.
module kcpsmx_scratch_dp
    import kcpsmx3_inc::*;
#(
    parameter int                DATA_W         = SCRATCH_DATA_W,
    parameter int                ADDR_W         = SCRATCH_ADDR_W,
    parameter int                READ_LATENCY   = 0,
    parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0,
    parameter bit                CLEAR_ON_RESET = 1'b1
) (
    input logic                 clk,
    input logic                 reset,
    kcpsmx_scratch_dp_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;

    kcpsmx_scratch_clr #(
        .DATA_W         (DATA_W),
        .ADDR_W         (ADDR_W),
        .CLEAR_VALUE    (CLEAR_VALUE),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clr (
        .clk        (clk),
        .reset      (reset),
        .a_addr     (bus.a_addr),
        .a_we       (bus.a_we),
        .a_wdata    (bus.a_wdata),
        .clear_req  (bus.clear_req),
        .busy       (bus.busy),
        .clear_done (bus.clear_done),
        .wr_dropped (bus.wr_dropped),
        .mem_we     (mem_we_s),
        .mem_waddr  (mem_waddr_s),
        .mem_wdata  (mem_wdata_s)
    );

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_waddr_s] <= mem_wdata_s;
        end
    end

    if (READ_LATENCY == 0) begin : g_comb_rd
        logic [DATA_W-1:0] a_rd_s, b_rd_s;

        // Asynchronous read, old data during a same-cycle write.
        always_comb begin
            if (bus.busy) begin
                a_rd_s = CLEAR_VALUE;
                b_rd_s = CLEAR_VALUE;
            end else begin
                a_rd_s = mem[bus.a_addr];
                b_rd_s = mem[bus.b_addr];
            end
        end

        assign bus.a_rdata = a_rd_s;
        assign bus.b_rdata = b_rd_s;
    end else if (READ_LATENCY == 1) begin : g_reg_rd
        logic [DATA_W-1:0] a_rd_nxt_s, b_rd_nxt_s;
        logic [DATA_W-1:0] a_rd_r, b_rd_r;

        // Write-first bypass: outside a sweep the write port carries port A's write.
        always_comb begin
            if (bus.busy) begin
                a_rd_nxt_s = CLEAR_VALUE;
                b_rd_nxt_s = CLEAR_VALUE;
            end else begin
                if (mem_we_s && (mem_waddr_s == bus.a_addr)) begin
                    a_rd_nxt_s = mem_wdata_s;
                end else begin
                    a_rd_nxt_s = mem[bus.a_addr];
                end
                if (mem_we_s && (mem_waddr_s == bus.b_addr)) begin
                    b_rd_nxt_s = mem_wdata_s;
                end else begin
                    b_rd_nxt_s = mem[bus.b_addr];
                end
            end
        end

        // Read data registers.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                a_rd_r <= '0;
                b_rd_r <= '0;
            end else begin
                a_rd_r <= a_rd_nxt_s;
                b_rd_r <= b_rd_nxt_s;
            end
        end

        assign bus.a_rdata = a_rd_r;
        assign bus.b_rdata = b_rd_r;
    end else begin : g_bad_latency
        $error("kcpsmx_scratch_dp: READ_LATENCY must be 0 or 1");
    end

endmodule
